// File: rtl/branch_redirect_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_redirect_unit_pkg                                     |
// | Description : Constants and types shared across the redirect unit: the     |
// |               datapath word width, the sequential PC increment, the branch |
// |               funct3 encodings and the link-register indices.              |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package branch_redirect_unit_pkg;

  localparam int unsigned      WORD         = 32;
  localparam logic [WORD-1:0]  WORD_ZERO    = '0;
  localparam int unsigned      PC_INCREMENT = 4;

  // Conditional-branch funct3 encodings; 3'b010 and 3'b011 are unused
  // and resolve as not taken.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  // Return-address registers: ra (x1) and the alternate link t0 (x5).
  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == LINK_RA) || (idx == LINK_T0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_redirect_unit_ras_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ras_stack                                                    |
// | Description : Circular return-address stack. A push onto a full stack      |
// |               overwrites the oldest entry; a pop from an empty stack is    |
// |               ignored. Push and pop together replace the top entry.        |
// | Ports       : clk_i, rst_i (async, active-low)                             |
// |               i_push, i_pop, i_data  - stack operation and push value      |
// |               o_top                  - top entry, zero when empty          |
// |               o_empty                - no valid entries                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty
);

  localparam int unsigned      c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_ptr;   // next write slot; the top lives at r_ptr-1
  logic [c_PTR_W:0]   r_cnt;

  logic [c_PTR_W-1:0] w_top_idx;
  logic               w_empty;
  logic               w_full;

  assign w_top_idx = r_ptr - c_PTR_W'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == c_DEPTH);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && i_pop && !w_empty) begin
      // Replace: the pop and the push cancel out on pointer and count.
      r_mem[w_top_idx] <= i_data;
    end else if (i_push) begin
      // Power-of-two depth lets the pointer wrap naturally; when full the
      // slot at r_ptr holds the oldest entry, which is the one overwritten.
      r_mem[r_ptr] <= i_data;
      r_ptr        <= r_ptr + c_PTR_W'(1);
      if (!w_full) begin
        r_cnt <= r_cnt + (c_PTR_W + 1)'(1);
      end
    end else if (i_pop && !w_empty) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (c_PTR_W + 1)'(1);
    end
  end

  assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_redirect_unit                                         |
// | Description : Resolves branch/JAL/JALR control flow for the single-cycle   |
// |               core with zero-cycle redirect to the PC generator, and       |
// |               tracks a return-address stack, a sticky misaligned-target    |
// |               flag and saturating performance counters.                   |
// | Ports       : clk_i, rst_i (async, active-low)                             |
// |               valid_i, pc_i, isBranch_i, isJal_i, isJalr_i, funct3_i,      |
// |               rs1Data_i, rs2Data_i, imm_i, rs1Idx_i, rdIdx_i - decode in   |
// |               brAddr_o, brBit_o   - redirect target / taken (comb)         |
// |               linkAddr_o          - pc_i + PC_INC (comb)                   |
// |               rasTop_o, rasEmpty_o, misalign_o                             |
// |               takenCnt_o, rasHitCnt_o, rasMissCnt_o - saturating counters  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned PC_INC    = PC_INCREMENT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] pc_i,
  input  logic              isBranch_i,
  input  logic              isJal_i,
  input  logic              isJalr_i,
  input  logic [2:0]        funct3_i,
  input  logic [WORD_W-1:0] rs1Data_i,
  input  logic [WORD_W-1:0] rs2Data_i,
  input  logic [WORD_W-1:0] imm_i,
  input  logic [4:0]        rs1Idx_i,
  input  logic [4:0]        rdIdx_i,
  output logic [WORD_W-1:0] brAddr_o,
  output logic              brBit_o,
  output logic [WORD_W-1:0] linkAddr_o,
  output logic [WORD_W-1:0] rasTop_o,
  output logic              rasEmpty_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  takenCnt_o,
  output logic [CNT_W-1:0]  rasHitCnt_o,
  output logic [CNT_W-1:0]  rasMissCnt_o
);

  logic [WORD_W-1:0] w_pc_tgt;
  logic [WORD_W-1:0] w_jalr_sum;
  logic [WORD_W-1:0] w_jalr_tgt;
  logic              w_eq;
  logic              w_lt_s;
  logic              w_lt_u;
  logic              w_cond;
  logic              w_taken;
  logic [WORD_W-1:0] w_target;
  logic              w_rd_link;
  logic              w_rs1_link;
  logic              w_push;
  logic              w_pop;
  logic              w_hit;
  logic              w_miss;
  logic [WORD_W-1:0] w_ras_top;
  logic              w_ras_empty;

  logic              r_misalign;
  logic [CNT_W-1:0]  r_taken_cnt;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  // Target adders; all sums wrap modulo 2^WORD_W.
  assign w_pc_tgt   = pc_i + imm_i;
  assign w_jalr_sum = rs1Data_i + imm_i;
  assign w_jalr_tgt = {w_jalr_sum[WORD_W-1:1], 1'b0};
  assign linkAddr_o = pc_i + WORD_W'(PC_INC);

  assign w_eq   = (rs1Data_i == rs2Data_i);
  assign w_lt_s = ($signed(rs1Data_i) < $signed(rs2Data_i));
  assign w_lt_u = (rs1Data_i < rs2Data_i);

  always_comb begin
    w_cond = 1'b0;
    case (br_funct3_e'(funct3_i))
      F3_BEQ:  w_cond = w_eq;
      F3_BNE:  w_cond = !w_eq;
      F3_BLT:  w_cond = w_lt_s;
      F3_BGE:  w_cond = !w_lt_s;
      F3_BLTU: w_cond = w_lt_u;
      F3_BGEU: w_cond = !w_lt_u;
      default: w_cond = 1'b0;
    endcase
  end

  // JALR outranks JAL, which outranks a conditional branch.
  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    if (valid_i) begin
      if (isJalr_i) begin
        w_target = w_jalr_tgt;
        w_taken  = 1'b1;
      end else if (isJal_i) begin
        w_target = w_pc_tgt;
        w_taken  = 1'b1;
      end else if (isBranch_i) begin
        w_target = w_pc_tgt;
        w_taken  = w_cond;
      end
    end
  end

  assign brAddr_o = w_target;
  assign brBit_o  = w_taken;

  // Return-address stack hints. A JALR that links through the same register
  // it jumps through is a plain call (push only); differing link registers
  // make it a coroutine swap (pop then push, i.e. replace the top).
  assign w_rd_link  = is_link(rdIdx_i);
  assign w_rs1_link = is_link(rs1Idx_i);
  assign w_push     = valid_i && (isJalr_i || isJal_i) && w_rd_link;
  assign w_pop      = valid_i && isJalr_i && w_rs1_link &&
                      !(w_rd_link && (rdIdx_i == rs1Idx_i));
  assign w_hit      = w_pop && !w_ras_empty && (w_ras_top == w_jalr_tgt);
  assign w_miss     = w_pop && !w_hit;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WORD_W)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (linkAddr_o),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );

  assign rasTop_o   = w_ras_top;
  assign rasEmpty_o = w_ras_empty;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_misalign  <= 1'b0;
      r_taken_cnt <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_taken && (w_target[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
      if (w_taken && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
      if (w_hit && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
      if (w_miss && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign misalign_o   = r_misalign;
  assign takenCnt_o   = r_taken_cnt;
  assign rasHitCnt_o  = r_hit_cnt;
  assign rasMissCnt_o = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_branch_redirect_unit                                      |
// | Description : Self-checking bench for branch_redirect_unit. A second       |
// |               instance with 3-bit counters exercises saturation.           |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid, isBr, isJal, isJalr;
  logic [2:0]  f3;
  logic [31:0] pc, rs1d, rs2d, imm;
  logic [4:0]  rs1i, rdi;

  logic [31:0] brAddr, linkAddr, rasTop;
  logic        brBit, rasEmpty, misalign;
  logic [15:0] takenCnt, hitCnt, missCnt;

  logic [31:0] s_brAddr, s_linkAddr, s_rasTop;
  logic        s_brBit, s_rasEmpty, s_misalign;
  logic [2:0]  s_takenCnt, s_hitCnt, s_missCnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb [$];
  logic [31:0] e;
  int          e_taken = 0;
  int          e_hit = 0;
  int          e_miss = 0;

  always #5 clk = ~clk;

  branch_redirect_unit #(.WORD_W(32), .RAS_DEPTH(4), .CNT_W(16), .PC_INC(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .pc_i(pc), .isBranch_i(isBr),
    .isJal_i(isJal), .isJalr_i(isJalr), .funct3_i(f3), .rs1Data_i(rs1d),
    .rs2Data_i(rs2d), .imm_i(imm), .rs1Idx_i(rs1i), .rdIdx_i(rdi),
    .brAddr_o(brAddr), .brBit_o(brBit), .linkAddr_o(linkAddr), .rasTop_o(rasTop),
    .rasEmpty_o(rasEmpty), .misalign_o(misalign), .takenCnt_o(takenCnt),
    .rasHitCnt_o(hitCnt), .rasMissCnt_o(missCnt)
  );

  branch_redirect_unit #(.WORD_W(32), .RAS_DEPTH(4), .CNT_W(3), .PC_INC(4)) u_sat (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .pc_i(pc), .isBranch_i(isBr),
    .isJal_i(isJal), .isJalr_i(isJalr), .funct3_i(f3), .rs1Data_i(rs1d),
    .rs2Data_i(rs2d), .imm_i(imm), .rs1Idx_i(rs1i), .rdIdx_i(rdi),
    .brAddr_o(s_brAddr), .brBit_o(s_brBit), .linkAddr_o(s_linkAddr), .rasTop_o(s_rasTop),
    .rasEmpty_o(s_rasEmpty), .misalign_o(s_misalign), .takenCnt_o(s_takenCnt),
    .rasHitCnt_o(s_hitCnt), .rasMissCnt_o(s_missCnt)
  );

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] r1, input logic [4:0] rd);
    valid = v; isBr = br; isJal = jal; isJalr = jalr; f3 = f;
    pc = p; rs1d = a; rs2d = b; imm = im; rs1i = r1; rdi = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd1);
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL rst_taken act=%h exp=%h", takenCnt, e); end
    total++; e = sb.pop_front(); if (32'(hitCnt) !== e) begin bad++; $display("FAIL rst_hit act=%h exp=%h", hitCnt, e); end
    total++; e = sb.pop_front(); if (32'(missCnt) !== e) begin bad++; $display("FAIL rst_miss act=%h exp=%h", missCnt, e); end
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL rst_empty act=%h exp=%h", rasEmpty, e); end
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL rst_top act=%h exp=%h", rasTop, e); end
    total++; e = sb.pop_front(); if (32'(misalign) !== e) begin bad++; $display("FAIL rst_misalign act=%h exp=%h", misalign, e); end
    total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL rst_brbit act=%h exp=%h", brBit, e); end
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL rst_braddr act=%h exp=%h", brAddr, e); end
    // Redirect logic stays live while reset is held.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'h8, 5'd0, 5'd1);
    sb.push_back(32'd1); sb.push_back(32'h108);
    #1;
    total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL rst_comb_bit act=%h exp=%h", brBit, e); end
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL rst_comb_addr act=%h exp=%h", brAddr, e); end
    tick(); tick();
    sb.push_back(32'd0); sb.push_back(32'd1);
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL rst_hold_taken act=%h exp=%h", takenCnt, e); end
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL rst_hold_empty act=%h exp=%h", rasEmpty, e); end
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_branch();
    logic [2:0]  tf [7] = '{3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    logic [31:0] ta [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
    logic [31:0] tb [7] = '{32'd7, 32'd1, 32'd1, 32'd1, 32'd1, 32'd7, 32'd7};
    logic        tk [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd7, 32'd7, 32'h20, 5'd0, 5'd0);
    sb.push_back(32'd1); sb.push_back(32'h120); sb.push_back(32'h104);
    #1;
    total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL beq_bit act=%h exp=%h", brBit, e); end
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL beq_addr act=%h exp=%h", brAddr, e); end
    total++; e = sb.pop_front(); if (linkAddr !== e) begin bad++; $display("FAIL beq_link act=%h exp=%h", linkAddr, e); end
    tick(); e_taken++;
    sb.push_back(32'(e_taken));
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL beq_cnt act=%h exp=%h", takenCnt, e); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, tf[i], 32'h100, ta[i], tb[i], 32'h20, 5'd0, 5'd0);
      sb.push_back(32'(tk[i])); sb.push_back(32'h120);
      #1;
      total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL br_bit f3=%b act=%h exp=%h", tf[i], brBit, e); end
      total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL br_addr f3=%b act=%h exp=%h", tf[i], brAddr, e); end
      tick();
      if (tk[i]) e_taken++;
    end
    sb.push_back(32'(e_taken));
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL br_cnt act=%h exp=%h", takenCnt, e); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd7, 32'd7, 32'h20, 5'd0, 5'd0);
    sb.push_back(32'd0); sb.push_back(32'd0);
    #1;
    total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL inval_bit act=%h exp=%h", brBit, e); end
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL inval_addr act=%h exp=%h", brAddr, e); end
    tick();
  endtask

  task automatic test_jal_jalr();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 32'h40, 5'd0, 5'd1);
    sb.push_back(32'h204); sb.push_back(32'h240);
    #1;
    total++; e = sb.pop_front(); if (linkAddr !== e) begin bad++; $display("FAIL jal_link act=%h exp=%h", linkAddr, e); end
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL jal_addr act=%h exp=%h", brAddr, e); end
    tick(); e_taken++;
    sb.push_back(32'h204);
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL jal_top act=%h exp=%h", rasTop, e); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h240, 32'h204, 32'h0, 32'h0, 5'd1, 5'd0);
    sb.push_back(32'h204);
    #1;
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL jalr_addr act=%h exp=%h", brAddr, e); end
    tick(); e_taken++; e_hit++;
    sb.push_back(32'(e_hit)); sb.push_back(32'd1); sb.push_back(32'd0);
    total++; e = sb.pop_front(); if (32'(hitCnt) !== e) begin bad++; $display("FAIL jalr_hit act=%h exp=%h", hitCnt, e); end
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL jalr_empty act=%h exp=%h", rasEmpty, e); end
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL jalr_top act=%h exp=%h", rasTop, e); end
    // All three type flags: JALR wins.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 32'h300, 32'h1000, 32'h5, 32'h10, 5'd2, 5'd0);
    sb.push_back(32'h1010); sb.push_back(32'd1);
    #1;
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL prio_jalr_addr act=%h exp=%h", brAddr, e); end
    total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL prio_jalr_bit act=%h exp=%h", brBit, e); end
    tick(); e_taken++;
    // JAL plus a failing branch: JAL wins and is taken.
    isJalr = 1'b0;
    sb.push_back(32'h310); sb.push_back(32'd1);
    #1;
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL prio_jal_addr act=%h exp=%h", brAddr, e); end
    total++; e = sb.pop_front(); if (32'(brBit) !== e) begin bad++; $display("FAIL prio_jal_bit act=%h exp=%h", brBit, e); end
    tick(); e_taken++;
    sb.push_back(32'(e_taken));
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL jj_cnt act=%h exp=%h", takenCnt, e); end
  endtask

  task automatic test_ras_wrap();
    logic [31:0] tops [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'(16 * (i + 1)), 32'h0, 32'h0, 32'h100, 5'd0, 5'd5);
      tick(); e_taken++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h400, tops[i], 32'h0, 32'h0, 5'd1, 5'd0);
      sb.push_back(tops[i]); sb.push_back(tops[i]);
      #1;
      total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL wrap_top%0d act=%h exp=%h", i, rasTop, e); end
      total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL wrap_addr%0d act=%h exp=%h", i, brAddr, e); end
      tick(); e_taken++; e_hit++;
    end
    sb.push_back(32'd1); sb.push_back(32'(e_hit));
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL wrap_empty act=%h exp=%h", rasEmpty, e); end
    total++; e = sb.pop_front(); if (32'(hitCnt) !== e) begin bad++; $display("FAIL wrap_hit act=%h exp=%h", hitCnt, e); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h400, 32'h24, 32'h0, 32'h0, 5'd1, 5'd0);
    tick(); e_taken++; e_miss++;
    sb.push_back(32'(e_miss)); sb.push_back(32'(e_taken));
    total++; e = sb.pop_front(); if (32'(missCnt) !== e) begin bad++; $display("FAIL wrap_miss act=%h exp=%h", missCnt, e); end
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL wrap_cnt act=%h exp=%h", takenCnt, e); end
    // Coroutine swap (rd=x5, rs1=x1): top replaced, depth unchanged.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h600, 32'h0, 32'h0, 32'h8, 5'd0, 5'd1);
    tick(); e_taken++;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h700, 32'h604, 32'h0, 32'h0, 5'd1, 5'd5);
    tick(); e_taken++; e_hit++;
    sb.push_back(32'h704); sb.push_back(32'd0); sb.push_back(32'(e_hit));
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL swap_top act=%h exp=%h", rasTop, e); end
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL swap_empty act=%h exp=%h", rasEmpty, e); end
    total++; e = sb.pop_front(); if (32'(hitCnt) !== e) begin bad++; $display("FAIL swap_hit act=%h exp=%h", hitCnt, e); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h704, 32'h704, 32'h0, 32'h0, 5'd5, 5'd0);
    tick(); e_taken++; e_hit++;
    sb.push_back(32'd1);
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL swap_pop_empty act=%h exp=%h", rasEmpty, e); end
    // rd == rs1 == x1: push only, neither hit nor miss.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h800, 32'h704, 32'h0, 32'h0, 5'd1, 5'd1);
    tick(); e_taken++;
    sb.push_back(32'h804); sb.push_back(32'(e_hit)); sb.push_back(32'(e_miss));
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL same_top act=%h exp=%h", rasTop, e); end
    total++; e = sb.pop_front(); if (32'(hitCnt) !== e) begin bad++; $display("FAIL same_hit act=%h exp=%h", hitCnt, e); end
    total++; e = sb.pop_front(); if (32'(missCnt) !== e) begin bad++; $display("FAIL same_miss act=%h exp=%h", missCnt, e); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h2, 5'd0, 5'd0);
    sb.push_back(32'h2); sb.push_back(32'd0);
    #1;
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL mis_addr act=%h exp=%h", brAddr, e); end
    total++; e = sb.pop_front(); if (32'(misalign) !== e) begin bad++; $display("FAIL mis_before act=%h exp=%h", misalign, e); end
    tick(); e_taken++;
    sb.push_back(32'd1);
    total++; e = sb.pop_front(); if (32'(misalign) !== e) begin bad++; $display("FAIL mis_set act=%h exp=%h", misalign, e); end
    idle(); tick(); tick();
    sb.push_back(32'd1);
    total++; e = sb.pop_front(); if (32'(misalign) !== e) begin bad++; $display("FAIL mis_sticky act=%h exp=%h", misalign, e); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h40, 32'h101, 32'h0, 32'h0, 5'd2, 5'd0);
    sb.push_back(32'h100);
    #1;
    total++; e = sb.pop_front(); if (brAddr !== e) begin bad++; $display("FAIL jalr_bit0 act=%h exp=%h", brAddr, e); end
    tick(); e_taken++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h900, 32'h0, 32'h0, 32'h20, 5'd0, 5'd1);
    tick(); e_taken++;
    pc = 32'h910;
    tick(); e_taken++;
    idle();
    sb.push_back(32'h914); sb.push_back(32'(e_taken));
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL mid_top act=%h exp=%h", rasTop, e); end
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL mid_cnt act=%h exp=%h", takenCnt, e); end
    #2 rst_n = 1'b0;
    #1;
    e_taken = 0; e_hit = 0; e_miss = 0;
    sb.push_back(32'd1); sb.push_back(32'd0); sb.push_back(32'd0);
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
    total++; e = sb.pop_front(); if (32'(rasEmpty) !== e) begin bad++; $display("FAIL amid_empty act=%h exp=%h", rasEmpty, e); end
    total++; e = sb.pop_front(); if (rasTop !== e) begin bad++; $display("FAIL amid_top act=%h exp=%h", rasTop, e); end
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL amid_taken act=%h exp=%h", takenCnt, e); end
    total++; e = sb.pop_front(); if (32'(hitCnt) !== e) begin bad++; $display("FAIL amid_hit act=%h exp=%h", hitCnt, e); end
    total++; e = sb.pop_front(); if (32'(missCnt) !== e) begin bad++; $display("FAIL amid_miss act=%h exp=%h", missCnt, e); end
    total++; e = sb.pop_front(); if (32'(misalign) !== e) begin bad++; $display("FAIL amid_misalign act=%h exp=%h", misalign, e); end
    tick();
    rst_n = 1'b1;
    // Entries were wiped, so a return now pops an empty stack.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h920, 32'h914, 32'h0, 32'h0, 5'd1, 5'd0);
    tick(); e_taken++; e_miss++;
    sb.push_back(32'(e_miss)); sb.push_back(32'(e_taken));
    total++; e = sb.pop_front(); if (32'(missCnt) !== e) begin bad++; $display("FAIL post_miss act=%h exp=%h", missCnt, e); end
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL post_taken act=%h exp=%h", takenCnt, e); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0);
      tick(); e_taken++;
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h40, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0);
      tick(); e_taken++; e_miss++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0, 32'h4, 5'd0, 5'd0);
    sb.push_back(32'(e_taken)); sb.push_back(32'(e_miss));
    sb.push_back(32'(sat7(e_taken))); sb.push_back(32'(sat7(e_miss))); sb.push_back(32'(sat7(e_hit)));
    sb.push_back(32'd1); sb.push_back(32'd0); sb.push_back(32'd0);
    sb.push_back(32'h24); sb.push_back(32'd1); sb.push_back(32'h24);
    #1;
    total++; e = sb.pop_front(); if (32'(takenCnt) !== e) begin bad++; $display("FAIL sat_main_taken act=%h exp=%h", takenCnt, e); end
    total++; e = sb.pop_front(); if (32'(missCnt) !== e) begin bad++; $display("FAIL sat_main_miss act=%h exp=%h", missCnt, e); end
    total++; e = sb.pop_front(); if (32'(s_takenCnt) !== e) begin bad++; $display("FAIL sat_taken act=%h exp=%h", s_takenCnt, e); end
    total++; e = sb.pop_front(); if (32'(s_missCnt) !== e) begin bad++; $display("FAIL sat_miss act=%h exp=%h", s_missCnt, e); end
    total++; e = sb.pop_front(); if (32'(s_hitCnt) !== e) begin bad++; $display("FAIL sat_hit act=%h exp=%h", s_hitCnt, e); end
    total++; e = sb.pop_front(); if (32'(s_rasEmpty) !== e) begin bad++; $display("FAIL sat_empty act=%h exp=%h", s_rasEmpty, e); end
    total++; e = sb.pop_front(); if (s_rasTop !== e) begin bad++; $display("FAIL sat_top act=%h exp=%h", s_rasTop, e); end
    total++; e = sb.pop_front(); if (32'(s_misalign) !== e) begin bad++; $display("FAIL sat_misalign act=%h exp=%h", s_misalign, e); end
    total++; e = sb.pop_front(); if (s_brAddr !== e) begin bad++; $display("FAIL sat_addr act=%h exp=%h", s_brAddr, e); end
    total++; e = sb.pop_front(); if (32'(s_brBit) !== e) begin bad++; $display("FAIL sat_bit act=%h exp=%h", s_brBit, e); end
    total++; e = sb.pop_front(); if (s_linkAddr !== e) begin bad++; $display("FAIL sat_link act=%h exp=%h", s_linkAddr, e); end
    tick(); e_taken++;
    idle();
    sb.push_back(32'd7);
    total++; e = sb.pop_front(); if (32'(s_takenCnt) !== e) begin bad++; $display("FAIL sat_hold act=%h exp=%h", s_takenCnt, e); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_branch();
    test_jal_jalr();
    test_ras_wrap();
    test_misalign();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
